// File: rtl/sdram_wr_req.sv
// sdram_wr_req: buffers user write words in a single-clock FIFO and, once a
// full burst is available, requests a burst from the SDRAM write engine.
// It pops one word per wr_ack and advances the burst address after each
// wr_end, wrapping inside [wr_addr_min, wr_addr_max].
module sdram_wr_req #(
  parameter int FIFO_AW = 10,
  parameter int DW      = 16
) (
  input  logic               wr_clk,
  input  logic               wr_rst_n,
  input  logic               user_wr_en,
  input  logic [DW-1:0]      user_wr_data,
  output logic [FIFO_AW:0]   fifo_cnt,
  output logic               fifo_full,
  output logic               overflow,
  input  logic [23:0]        wr_addr_min,
  input  logic [23:0]        wr_addr_max,
  input  logic               addr_load,
  input  logic [9:0]         bst_len,
  input  logic               init_end,
  output logic               wr_en,
  output logic [23:0]        wr_addr,
  output logic [9:0]         wr_bst_len,
  output logic [DW-1:0]      wr_data,
  input  logic               wr_ack,
  input  logic               wr_end,
  output logic               busy
);

  localparam int                 DEPTH     = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   DEPTH_CNT = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  logic [DW-1:0]        mem [DEPTH];

  state_t               state_q, state_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     cnt_q, cnt_d;
  logic                 overflow_q, overflow_d;
  logic                 wr_en_q, wr_en_d;
  logic [23:0]          wr_addr_q, wr_addr_d;
  logic [9:0]           wr_bst_len_q, wr_bst_len_d;
  logic [DW-1:0]        wr_data_q, wr_data_d;
  logic [9:0]           pop_cnt_q, pop_cnt_d;
  logic                 addr_pend_q, addr_pend_d;

  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 start;
  logic [24:0]          nxt_addr;
  logic [24:0]          end_addr;

  assign full = (cnt_q == DEPTH_CNT);

  // Next-state logic for the FIFO, the request FSM and the address generator.
  always_comb begin
    push  = user_wr_en && !full;
    // Empty check is belt-and-braces: a request is only raised with enough data.
    pop   = ((state_q == REQ) || (state_q == XFER)) && wr_ack &&
            (pop_cnt_q < wr_bst_len_q) && (cnt_q != '0);
    start = init_end && (bst_len != 10'd0) && (bst_len <= 10'd512) &&
            ({{(31 - FIFO_AW){1'b0}}, cnt_q} >= {22'd0, bst_len});

    wr_ptr_d     = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    wr_data_d    = pop  ? mem[rd_ptr_q] : wr_data_q;
    cnt_d        = cnt_q;
    if (push && !pop) cnt_d = cnt_q + (FIFO_AW + 1)'(1);
    if (pop && !push) cnt_d = cnt_q - (FIFO_AW + 1)'(1);

    // A push into a full FIFO wins over a same-cycle clear.
    overflow_d   = (overflow_q && !addr_load) || (user_wr_en && full);

    state_d      = state_q;
    wr_en_d      = wr_en_q;
    wr_addr_d    = wr_addr_q;
    wr_bst_len_d = wr_bst_len_q;
    pop_cnt_d    = pop ? pop_cnt_q + 10'd1 : pop_cnt_q;
    addr_pend_d  = addr_pend_q;

    // 25-bit math so the window check cannot overflow near the top of memory.
    nxt_addr     = {1'b0, wr_addr_q} + {15'd0, wr_bst_len_q};
    end_addr     = nxt_addr + {15'd0, wr_bst_len_q} - 25'd1;

    case (state_q)
      IDLE: begin
        if (addr_load) wr_addr_d = wr_addr_min;
        if (start) begin
          state_d      = REQ;
          wr_en_d      = 1'b1;
          wr_bst_len_d = bst_len;
          pop_cnt_d    = 10'd0;
        end
      end
      REQ: begin
        if (addr_load) addr_pend_d = 1'b1;
        // Drop the request on the first ack so the engine never re-triggers.
        if (wr_ack) begin
          wr_en_d = 1'b0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (addr_load) addr_pend_d = 1'b1;
        if (wr_end) state_d = DONE;
      end
      DONE: begin
        state_d     = IDLE;
        addr_pend_d = 1'b0;
        // A load arriving in DONE itself is applied here rather than deferred.
        if (addr_pend_q || addr_load) begin
          wr_addr_d = wr_addr_min;
        end else if (end_addr > {1'b0, wr_addr_max}) begin
          wr_addr_d = wr_addr_min;
        end else begin
          wr_addr_d = nxt_addr[23:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage: write port only, no reset so it can map onto RAM.
  always_ff @(posedge wr_clk) begin
    if (push) mem[wr_ptr_q] <= user_wr_data;
  end

  // Control and output registers with asynchronous active-low reset.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      overflow_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 24'd0;
      wr_bst_len_q <= 10'd0;
      wr_data_q    <= '0;
      pop_cnt_q    <= 10'd0;
      addr_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      overflow_q   <= overflow_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_bst_len_q <= wr_bst_len_d;
      wr_data_q    <= wr_data_d;
      pop_cnt_q    <= pop_cnt_d;
      addr_pend_q  <= addr_pend_d;
    end
  end

  assign fifo_cnt   = cnt_q;
  assign fifo_full  = full;
  assign overflow   = overflow_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_bst_len = wr_bst_len_q;
  assign wr_data    = wr_data_q;
  assign busy       = (state_q != IDLE);

endmodule
